// File: rtl/bp_fe_mem_arbiter.sv
// FE memory command port arbiter: maintenance ops win over speculative fetches,
// fences drain outstanding fetches first, fetches are bounded by a credit counter.
module bp_fe_mem_arbiter #(
  parameter int vaddr_width_p   = 39,
  parameter int entry_width_p   = 64,
  parameter int fetch_credits_p = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     fetch_v_i,
  input  logic [vaddr_width_p-1:0] fetch_vaddr_i,
  output logic                     fetch_yumi_o,
  input  logic                     maint_v_i,
  input  logic [1:0]               maint_op_i,
  input  logic [vaddr_width_p-1:0] maint_vaddr_i,
  input  logic [entry_width_p-1:0] maint_entry_i,
  output logic                     maint_yumi_o,
  output logic                     mem_cmd_v_o,
  output logic [1:0]               mem_cmd_op_o,
  output logic [vaddr_width_p-1:0] mem_cmd_vaddr_o,
  output logic [entry_width_p-1:0] mem_cmd_entry_o,
  input  logic                     mem_cmd_yumi_i,
  input  logic                     mem_resp_v_i,
  input  logic                     mem_fence_done_i,
  output logic                     busy_o
);

  localparam int cw_lp = $clog2(fetch_credits_p + 1);
  localparam logic [cw_lp-1:0] max_credits_lp = cw_lp'(fetch_credits_p);

  typedef enum logic [1:0] {e_ready, e_drain, e_fence} state_e;

  state_e           state_q, state_d;
  logic [cw_lp-1:0] credits_q, credits_d;
  logic             is_fill, is_fence, full, credit_inc;
  logic             grant_fetch, grant_maint;

  always_comb begin
    is_fill     = (maint_op_i == 2'b01);
    is_fence    = maint_op_i[1];
    full        = (credits_q == max_credits_lp);
    grant_fetch = 1'b0;
    grant_maint = 1'b0;
    state_d     = state_q;
    unique case (state_q)
      e_ready: begin
        if (maint_v_i) begin
          if (is_fill || (is_fence && full)) grant_maint = 1'b1;
          else if (is_fence)                 state_d     = e_drain;
        end else if (fetch_v_i && (credits_q != '0)) begin
          grant_fetch = 1'b1;
        end
        if (grant_maint && mem_cmd_yumi_i && is_fence) state_d = e_fence;
      end
      e_drain: begin
        if (!maint_v_i) begin
          state_d = e_ready;
        end else if (full) begin
          grant_maint = 1'b1;
          if (mem_cmd_yumi_i) state_d = is_fence ? e_fence : e_ready;
        end
      end
      e_fence: if (mem_fence_done_i) state_d = e_ready;
      default: state_d = e_ready;
    endcase
    // Outputs are held quiet while reset is asserted.
    if (reset_i) begin
      grant_fetch = 1'b0;
      grant_maint = 1'b0;
    end
  end

  assign fetch_yumi_o    = mem_cmd_yumi_i & grant_fetch;
  assign maint_yumi_o    = mem_cmd_yumi_i & grant_maint;
  assign mem_cmd_v_o     = grant_fetch | grant_maint;
  assign mem_cmd_op_o    = grant_maint ? maint_op_i : 2'b00;
  assign mem_cmd_vaddr_o = grant_maint ? maint_vaddr_i
                         : (grant_fetch ? fetch_vaddr_i : '0);
  assign mem_cmd_entry_o = (grant_maint && is_fill) ? maint_entry_i : '0;
  assign busy_o          = !reset_i && (state_q != e_ready);

  // A response arriving with all credits home is spurious and dropped.
  assign credit_inc = mem_resp_v_i && !full;
  assign credits_d  = credits_q + cw_lp'(credit_inc) - cw_lp'(fetch_yumi_o);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= e_ready;
      credits_q <= max_credits_lp;
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(mem_resp_v_i && full));
      assert (!(mem_fence_done_i && (state_q != e_fence)));
      assert (!(maint_v_i && (maint_op_i == 2'b00)));
    end
  end

  maint_stable_a: assert property (@(posedge clk_i) disable iff (reset_i)
    (state_q == e_drain && maint_v_i) |->
      ($stable(maint_op_i) && $stable(maint_vaddr_i) && $stable(maint_entry_i)));
`endif

endmodule

// File: tb/tb_bp_fe_mem_arbiter.sv
// Bench for bp_fe_mem_arbiter: vector table, directed multi-cycle sequences and
// randomized traffic against an outstanding-count / pending-fence reference model.
module tb_bp_fe_mem_arbiter;
  localparam int VW = 39;
  localparam int EW = 64;
  localparam int CREDITS = 2;

  logic          clk = 1'b0, reset = 1'b1;
  logic          fetch_v, maint_v, cmd_yumi, resp_v, fence_done;
  logic [VW-1:0] fetch_va, maint_va;
  logic [1:0]    maint_op;
  logic [EW-1:0] maint_en;
  logic          fetch_yumi, maint_yumi, cmd_v, busy;
  logic [1:0]    cmd_op;
  logic [VW-1:0] cmd_va;
  logic [EW-1:0] cmd_en;

  int nchk = 0, nerr = 0;

  bp_fe_mem_arbiter #(.vaddr_width_p(VW), .entry_width_p(EW), .fetch_credits_p(CREDITS)) dut (
    .clk_i(clk), .reset_i(reset),
    .fetch_v_i(fetch_v), .fetch_vaddr_i(fetch_va), .fetch_yumi_o(fetch_yumi),
    .maint_v_i(maint_v), .maint_op_i(maint_op), .maint_vaddr_i(maint_va),
    .maint_entry_i(maint_en), .maint_yumi_o(maint_yumi),
    .mem_cmd_v_o(cmd_v), .mem_cmd_op_o(cmd_op), .mem_cmd_vaddr_o(cmd_va),
    .mem_cmd_entry_o(cmd_en), .mem_cmd_yumi_i(cmd_yumi),
    .mem_resp_v_i(resp_v), .mem_fence_done_i(fence_done), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic fv; logic [VW-1:0] fa;
    logic mv; logic [1:0] mop; logic [VW-1:0] ma; logic [EW-1:0] me;
    logic yumi;
    logic e_v; logic [1:0] e_op; logic [VW-1:0] e_va; logic [EW-1:0] e_en;
    logic e_fy; logic e_my;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic setin(input logic fv, input logic [VW-1:0] fa, input logic mv,
                       input logic [1:0] mop, input logic [VW-1:0] ma, input logic [EW-1:0] me,
                       input logic yumi, input logic resp, input logic done);
    fetch_v = fv; fetch_va = fa; maint_v = mv; maint_op = mop; maint_va = ma;
    maint_en = me; cmd_yumi = yumi; resp_v = resp; fence_done = done;
  endtask

  // Checks combinational outputs mid-cycle, then advances to the next negedge.
  task automatic expect_cmd(input string tag, input logic v, input logic [1:0] op,
                            input logic [VW-1:0] va, input logic fy, input logic my,
                            input logic bsy);
    #1;
    chk({tag, ".v"}, 64'(cmd_v), 64'(v));
    chk({tag, ".op"}, 64'(cmd_op), 64'(op));
    chk({tag, ".vaddr"}, 64'(cmd_va), 64'(va));
    chk({tag, ".fetch_yumi"}, 64'(fetch_yumi), 64'(fy));
    chk({tag, ".maint_yumi"}, 64'(maint_yumi), 64'(my));
    chk({tag, ".busy"}, 64'(busy), 64'(bsy));
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    setin(0, '0, 0, 2'b00, '0, '0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // reference model state
  int            outst;
  bit            fence_fly, wait_f, mreq;
  logic [1:0]    r_op;
  logic [VW-1:0] r_ma, r_fa;
  logic [EW-1:0] r_me;
  logic          r_fv, r_yumi, r_resp, r_done, eg_m, eg_f;
  logic [VW-1:0] e_va;

  initial begin
    tbl[0] = '{1, 39'h123,  0, 2'b00, 39'h0,    64'h0,    1, 1, 2'b00, 39'h123,  64'h0,    1, 0};
    tbl[1] = '{1, 39'h40,   1, 2'b01, 39'h1000, 64'hdead, 1, 1, 2'b01, 39'h1000, 64'hdead, 0, 1};
    tbl[2] = '{0, 39'h0,    1, 2'b10, 39'h2000, 64'hbeef, 0, 1, 2'b10, 39'h2000, 64'h0,    0, 0};
    tbl[3] = '{1, 39'h44,   1, 2'b11, 39'h2400, 64'h55,   1, 1, 2'b11, 39'h2400, 64'h0,    0, 1};
    tbl[4] = '{0, 39'h48,   0, 2'b01, 39'h2800, 64'h66,   0, 0, 2'b00, 39'h0,    64'h0,    0, 0};
    tbl[5] = '{1, 39'h7abc, 0, 2'b00, 39'h0,    64'h0,    0, 1, 2'b00, 39'h7abc, 64'h0,    0, 0};
    tbl[6] = '{0, 39'h0,    1, 2'b01, 39'h3c00, 64'h1234, 0, 1, 2'b01, 39'h3c00, 64'h1234, 0, 0};
    tbl[7] = '{1, 39'h4c,   1, 2'b10, 39'h4400, 64'h99,   1, 1, 2'b10, 39'h4400, 64'h0,    0, 1};

    // Reset state: requests present but outputs must stay zero.
    setin(1, 39'habc, 1, 2'b01, 39'h1000, 64'h1, 1, 0, 0);
    @(negedge clk);
    #1;
    chk("reset.v", 64'(cmd_v), 64'h0);
    chk("reset.op", 64'(cmd_op), 64'h0);
    chk("reset.entry", cmd_en, 64'h0);
    chk("reset.yumi", 64'({fetch_yumi, maint_yumi}), 64'h0);
    chk("reset.busy", 64'(busy), 64'h0);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      setin(tbl[i].fv, tbl[i].fa, tbl[i].mv, tbl[i].mop, tbl[i].ma, tbl[i].me, tbl[i].yumi, 0, 0);
      #1;
      chk($sformatf("vec%0d.v", i), 64'(cmd_v), 64'(tbl[i].e_v));
      chk($sformatf("vec%0d.op", i), 64'(cmd_op), 64'(tbl[i].e_op));
      chk($sformatf("vec%0d.vaddr", i), 64'(cmd_va), 64'(tbl[i].e_va));
      chk($sformatf("vec%0d.entry", i), cmd_en, tbl[i].e_en);
      chk($sformatf("vec%0d.fetch_yumi", i), 64'(fetch_yumi), 64'(tbl[i].e_fy));
      chk($sformatf("vec%0d.maint_yumi", i), 64'(maint_yumi), 64'(tbl[i].e_my));
    end

    // Credit exhaustion, then resp alone, then resp + fetch in the same cycle.
    do_reset();
    setin(1, 39'h100, 0, 2'b00, '0, '0, 1, 0, 0); expect_cmd("t1.f0", 1, 0, 39'h100, 1, 0, 0);
    setin(1, 39'h104, 0, 2'b00, '0, '0, 1, 0, 0); expect_cmd("t1.f1", 1, 0, 39'h104, 1, 0, 0);
    setin(1, 39'h108, 0, 2'b00, '0, '0, 1, 0, 0); expect_cmd("t1.empty0", 0, 0, 0, 0, 0, 0);
    setin(1, 39'h108, 0, 2'b00, '0, '0, 1, 0, 0); expect_cmd("t1.empty1", 0, 0, 0, 0, 0, 0);
    setin(1, 39'h108, 0, 2'b00, '0, '0, 1, 1, 0); expect_cmd("t1.resp", 0, 0, 0, 0, 0, 0);
    setin(1, 39'h10c, 0, 2'b00, '0, '0, 1, 1, 0); expect_cmd("t2.both", 1, 0, 39'h10c, 1, 0, 0);
    setin(1, 39'h110, 0, 2'b00, '0, '0, 1, 0, 0); expect_cmd("t2.next", 1, 0, 39'h110, 1, 0, 0);
    setin(1, 39'h114, 0, 2'b00, '0, '0, 1, 0, 0); expect_cmd("t2.empty", 0, 0, 0, 0, 0, 0);

    // I$ fence with two fetches out: drain, issue, wait for done.
    setin(0, '0, 1, 2'b11, 39'h3000, 64'hff, 1, 0, 0); expect_cmd("t4.req", 0, 0, 0, 0, 0, 0);
    setin(0, '0, 1, 2'b11, 39'h3000, 64'hff, 1, 1, 0); expect_cmd("t4.drain0", 0, 0, 0, 0, 0, 1);
    setin(0, '0, 1, 2'b11, 39'h3000, 64'hff, 1, 1, 0); expect_cmd("t4.drain1", 0, 0, 0, 0, 0, 1);
    setin(0, '0, 1, 2'b11, 39'h3000, 64'hff, 1, 0, 0); expect_cmd("t4.issue", 1, 2'b11, 39'h3000, 0, 1, 1);
    setin(1, 39'h200, 0, 2'b00, '0, '0, 1, 0, 1);      expect_cmd("t4.fence", 0, 0, 0, 0, 0, 1);
    setin(1, 39'h204, 0, 2'b00, '0, '0, 1, 0, 0);      expect_cmd("t4.resume", 1, 0, 39'h204, 1, 0, 0);

    // Reset while draining with no credits left.
    setin(1, 39'h208, 0, 2'b00, '0, '0, 1, 0, 0);      expect_cmd("t5.f", 1, 0, 39'h208, 1, 0, 0);
    setin(0, '0, 1, 2'b10, 39'h4000, 64'h0, 1, 0, 0);  expect_cmd("t5.req", 0, 0, 0, 0, 0, 0);
    setin(0, '0, 1, 2'b10, 39'h4000, 64'h0, 1, 0, 0);  expect_cmd("t5.drain", 0, 0, 0, 0, 0, 1);
    reset = 1'b1;
    setin(1, 39'h300, 0, 2'b00, '0, '0, 1, 0, 0);      expect_cmd("t5.inreset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    setin(1, 39'h300, 0, 2'b00, '0, '0, 1, 0, 0);      expect_cmd("t5.f0", 1, 0, 39'h300, 1, 0, 0);
    setin(1, 39'h304, 0, 2'b00, '0, '0, 1, 0, 0);      expect_cmd("t5.f1", 1, 0, 39'h304, 1, 0, 0);
    setin(1, 39'h308, 0, 2'b00, '0, '0, 1, 0, 0);      expect_cmd("t5.empty", 0, 0, 0, 0, 0, 0);

    // Fill stalled by memory for three cycles; credits untouched.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      setin(1, 39'h500, 1, 2'b01, 39'h5555, 64'h77, 0, 0, 0);
      #1;
      chk($sformatf("t6.entry%0d", i), cmd_en, 64'h77);
      expect_cmd($sformatf("t6.hold%0d", i), 1, 2'b01, 39'h5555, 0, 0, 0);
    end
    setin(1, 39'h600, 0, 2'b00, '0, '0, 1, 0, 0); expect_cmd("t6.f0", 1, 0, 39'h600, 1, 0, 0);
    setin(1, 39'h604, 0, 2'b00, '0, '0, 1, 0, 0); expect_cmd("t6.f1", 1, 0, 39'h604, 1, 0, 0);
    setin(1, 39'h608, 0, 2'b00, '0, '0, 1, 0, 0); expect_cmd("t6.empty", 0, 0, 0, 0, 0, 0);

    // Randomized traffic against the reference model.
    do_reset();
    outst = 0; fence_fly = 0; wait_f = 0; mreq = 0;
    r_op = 2'b01; r_ma = '0; r_me = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!mreq && ($urandom_range(7) == 0)) begin
        mreq = 1;
        r_op = 2'($urandom_range(3, 1));
        r_ma = {7'($urandom), 32'($urandom)};
        r_me = {32'($urandom), 32'($urandom)};
      end
      r_fv   = ($urandom_range(1) == 1);
      r_fa   = {7'($urandom), 32'($urandom)};
      r_yumi = ($urandom_range(9) < 6);
      r_resp = (outst > 0) && ($urandom_range(2) == 0);
      r_done = fence_fly && ($urandom_range(3) == 0);

      eg_m = 0; eg_f = 0;
      if (fence_fly)     ;
      else if (wait_f)   eg_m = mreq && (outst == 0);
      else if (mreq)     eg_m = (r_op == 2'b01) || (outst == 0);
      else               eg_f = r_fv && (outst < CREDITS);
      e_va = eg_m ? r_ma : (eg_f ? r_fa : '0);

      setin(r_fv, r_fa, mreq, r_op, r_ma, r_me, r_yumi, r_resp, r_done);
      #1;
      chk("rnd.v", 64'(cmd_v), 64'(eg_m | eg_f));
      chk("rnd.op", 64'(cmd_op), 64'(eg_m ? r_op : 2'b00));
      chk("rnd.vaddr", 64'(cmd_va), 64'(e_va));
      chk("rnd.entry", cmd_en, (eg_m && r_op == 2'b01) ? r_me : 64'h0);
      chk("rnd.fetch_yumi", 64'(fetch_yumi), 64'(eg_f & r_yumi));
      chk("rnd.maint_yumi", 64'(maint_yumi), 64'(eg_m & r_yumi));
      chk("rnd.busy", 64'(busy), 64'(fence_fly | wait_f));

      if (eg_m && r_yumi) begin
        mreq = 0;
        wait_f = 0;
        if (r_op != 2'b01) fence_fly = 1;
      end else if (!fence_fly && !wait_f && mreq && r_op != 2'b01 && outst > 0) begin
        wait_f = 1;
      end
      if (r_done) fence_fly = 0;
      outst = outst + ((eg_f && r_yumi) ? 1 : 0) - (r_resp ? 1 : 0);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
